// File: rtl/divide.sv
// Iterative 16/8 unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered and held until the next accepted operation completes.
module divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [3:0]  count_q, count_d;
    logic [15:0] work_q, work_d;      // dividend bits shift out, quotient bits shift in
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  dsr_q, dsr_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;

    logic        accept;
    logic        load;
    logic        zero_op;
    logic        last_step;

    logic [8:0]  partial;
    logic [8:0]  diff;
    logic        ge;
    logic [7:0]  step_rem;
    logic [15:0] step_quo;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = (divisor == 8'd0) ? StDone : StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (count_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and control decode
    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        accept    = start && (state_q != StRun);
        load      = accept && (divisor != 8'd0);
        zero_op   = accept && (divisor == 8'd0);
        last_step = (state_q == StRun) && (count_q == 4'd15);
    end

    // One restoring step; partial needs 9 bits since rem can be up to divisor-1 before the shift
    always_comb begin
        partial  = {rem_q, work_q[15]};
        diff     = partial - {1'b0, dsr_q};
        ge       = (partial >= {1'b0, dsr_q});
        step_rem = ge ? diff[7:0] : partial[7:0];
        step_quo = {work_q[14:0], ge};
    end

    always_comb begin
        count_d     = count_q;
        work_d      = work_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        if (load) begin
            work_d     = dividend;
            rem_d      = 8'd0;
            dsr_d      = divisor;
            count_d    = 4'd0;
            div_zero_d = 1'b0;
        end else if (zero_op) begin
            count_d     = 4'd0;
            quotient_d  = 16'hFFFF;
            remainder_d = dividend[7:0];
            div_zero_d  = 1'b1;
        end else if (busy) begin
            work_d  = step_quo;
            rem_d   = step_rem;
            count_d = count_q + 4'd1;
            if (last_step) begin
                quotient_d  = step_quo;
                remainder_d = step_rem;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 4'd0;
            work_q      <= 16'd0;
            rem_q       <= 8'd0;
            dsr_q       <= 8'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: stimulus pushes expected results, a negedge monitor
// pops and compares them whenever done is presented.
module tb_divide;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned done_count;
    logic        prev_done;

    divide dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q      = q;
        e.r      = r;
        e.dz     = dz;
        e.cyc    = cyc + (dz ? 1 : 17);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_within_bound", {31'd0, done}, 32'd1);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_quotient"}, {16'd0, quotient}, 32'd0);
        check({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
        check({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Monitor
    initial begin
        prev_done  = 1'b0;
        done_count = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_done) begin
                check("done_single_cycle", {31'd0, done}, 32'd0);
            end
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {16'd0, quotient}, {16'd0, e.q});
                    check("remainder", {24'd0, remainder}, {24'd0, e.r});
                    check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    check("latency", cyc, e.cyc);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int unsigned dc;

        vecs[0] = '{16'd100,   8'd10,  16'd10,    8'd0,   1'b0};
        vecs[1] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0};
        vecs[2] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0};
        vecs[3] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0};
        vecs[4] = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0};
        vecs[5] = '{16'd7,     8'd200, 16'd0,     8'd7,   1'b0};
        vecs[6] = '{16'd40000, 8'd200, 16'd200,   8'd0,   1'b0};
        vecs[7] = '{16'd54321, 8'd77,  16'd705,   8'd36,  1'b0};
        vecs[8] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};
        vecs[9] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        #1;
        check_zeroed("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic operation with busy visible during RUN
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        wait_done();

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            wait_done();
        end

        // Back-to-back starts issued while in DONE
        @(negedge clk);
        issue(16'd12345, 8'd123, 16'd100, 8'd45, 1'b0);
        wait_done();
        issue(16'd65535, 8'd2, 16'd32767, 8'd1, 1'b0);
        wait_done();
        issue(16'd300, 8'd255, 16'd1, 8'd45, 1'b0);
        wait_done();

        // Divide by zero, then an ordinary op straight out of DONE
        @(negedge clk);
        issue(16'd5, 8'd0, 16'hFFFF, 8'd5, 1'b1);
        check("dz_busy_low", {31'd0, busy}, 32'd0);
        wait_done();
        issue(16'd10, 8'd3, 16'd3, 8'd1, 1'b0);
        wait_done();

        // Start during RUN is ignored
        @(negedge clk);
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 16'd500;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done();

        // Asynchronous reset mid-RUN aborts the operation
        @(negedge clk);
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zeroed("async_reset");
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst = 1'b0;
        dc  = done_count;
        repeat (25) @(negedge clk);
        check("no_done_after_reset", done_count, dc);
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
